// File: rtl/rs_issue_sched_pkg.sv
// Shared constants, row type and helpers
// for the RS issue scheduler.
package rs_issue_sched_pkg;

  localparam int RS_DEPTH = 16;
  localparam int NUM_FU   = 3;
  localparam int PREG_W   = 6;
  localparam int ROB_W    = 4;
  localparam int IDX_W    = $clog2(RS_DEPTH);
  localparam int CNT_W    = IDX_W + 1;

  typedef struct packed {
    logic              valid;
    logic [1:0]        fu;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic              rdy1;
    logic              rdy2;
    logic [ROB_W-1:0]  rob;
  } sched_row_t;

  // True when any valid result bus carries tag.
  function automatic logic f_hit(
    input logic [PREG_W-1:0]        tag,
    input logic [NUM_FU-1:0]        vld,
    input logic [NUM_FU*PREG_W-1:0] preg
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (vld[k] && preg[k*PREG_W +: PREG_W] == tag)
        hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [CNT_W-1:0] f_popcnt(
    input logic [RS_DEPTH-1:0] v
  );
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      n = n + CNT_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/rs_issue_sched_if.sv
// Dispatch / wakeup / issue bundle between
// the scheduler and its neighbours.
interface rs_issue_sched_if;
  import rs_issue_sched_pkg::*;

  logic                     flush;
  logic                     alloc_valid_1;
  logic                     alloc_valid_2;
  logic [1:0]               alloc_fu_1;
  logic [1:0]               alloc_fu_2;
  logic [PREG_W-1:0]        alloc_ps1_1;
  logic [PREG_W-1:0]        alloc_ps2_1;
  logic [PREG_W-1:0]        alloc_ps1_2;
  logic [PREG_W-1:0]        alloc_ps2_2;
  logic                     alloc_rdy1_1;
  logic                     alloc_rdy2_1;
  logic                     alloc_rdy1_2;
  logic                     alloc_rdy2_2;
  logic [ROB_W-1:0]         alloc_rob_1;
  logic [ROB_W-1:0]         alloc_rob_2;
  logic [IDX_W-1:0]         alloc_idx_1;
  logic [IDX_W-1:0]         alloc_idx_2;
  logic                     alloc_stall;
  logic [NUM_FU-1:0]        wb_valid;
  logic [NUM_FU*PREG_W-1:0] wb_preg;
  logic [NUM_FU-1:0]        fu_busy;
  logic [NUM_FU-1:0]        issue_valid;
  logic [NUM_FU*IDX_W-1:0]  issue_idx;
  logic [NUM_FU*ROB_W-1:0]  issue_rob;
  logic [CNT_W-1:0]         free_count;

  modport master (
    output flush,
    output alloc_valid_1, alloc_valid_2,
    output alloc_fu_1, alloc_fu_2,
    output alloc_ps1_1, alloc_ps2_1,
    output alloc_ps1_2, alloc_ps2_2,
    output alloc_rdy1_1, alloc_rdy2_1,
    output alloc_rdy1_2, alloc_rdy2_2,
    output alloc_rob_1, alloc_rob_2,
    output wb_valid, wb_preg, fu_busy,
    input  alloc_idx_1, alloc_idx_2,
    input  alloc_stall,
    input  issue_valid, issue_idx, issue_rob,
    input  free_count
  );

  modport slave (
    input  flush,
    input  alloc_valid_1, alloc_valid_2,
    input  alloc_fu_1, alloc_fu_2,
    input  alloc_ps1_1, alloc_ps2_1,
    input  alloc_ps1_2, alloc_ps2_2,
    input  alloc_rdy1_1, alloc_rdy2_1,
    input  alloc_rdy1_2, alloc_rdy2_2,
    input  alloc_rob_1, alloc_rob_2,
    input  wb_valid, wb_preg, fu_busy,
    output alloc_idx_1, alloc_idx_2,
    output alloc_stall,
    output issue_valid, issue_idx, issue_rob,
    output free_count
  );

endinterface

// File: rtl/rs_issue_sched_age_select.sv
// Oldest-request picker: grants the request
// that no other request is older than.
module rs_age_select
  import rs_issue_sched_pkg::*;
(
  input  logic [RS_DEPTH-1:0]               i_req,
  input  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] i_older,
  output logic [RS_DEPTH-1:0]               o_gnt,
  output logic [IDX_W-1:0]                  o_idx,
  output logic                              o_valid
);

  // Row i wins unless some other requester is older.
  always_comb begin
    o_gnt = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      o_gnt[i] = i_req[i];
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (i_req[j] && i_older[j][i])
          o_gnt[i] = 1'b0;
      end
    end
  end

  // One-hot grant to binary index.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (o_gnt[i])
        o_idx = IDX_W'(i);
    end
  end

  assign o_valid = |o_gnt;

endmodule

// File: rtl/rs_issue_sched.sv
// Oldest-ready issue scheduler for the
// reservation station (indices/tags only).
module rs_issue_sched
  import rs_issue_sched_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  rs_issue_sched_if.slave sched
);

  sched_row_t                        r_row [RS_DEPTH];
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] r_older;
  logic [NUM_FU-1:0]                 r_iss_vld;
  logic [NUM_FU-1:0][IDX_W-1:0]      r_iss_idx;
  logic [NUM_FU-1:0][ROB_W-1:0]      r_iss_rob;

  logic [RS_DEPTH-1:0]               w_valid;
  logic [IDX_W-1:0]                  w_idx1;
  logic [IDX_W-1:0]                  w_idx2;
  logic                              w_found1;
  logic                              w_found2;
  logic [CNT_W-1:0]                  w_free;
  logic                              w_stall;
  logic                              w_clr;
  logic                              w_acc1;
  logic                              w_acc2;
  sched_row_t                        w_new1;
  sched_row_t                        w_new2;
  logic [NUM_FU-1:0][RS_DEPTH-1:0]   w_req;
  logic [NUM_FU-1:0][RS_DEPTH-1:0]   w_gnt;
  logic [NUM_FU-1:0][IDX_W-1:0]      w_gidx;
  logic [NUM_FU-1:0]                 w_gval;
  logic [RS_DEPTH-1:0]               w_issued;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] w_older_nxt;

  // Occupancy vector from row state.
  always_comb begin
    w_valid = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      w_valid[i] = r_row[i].valid;
  end

  // Lowest and next-lowest free rows.
  always_comb begin
    w_idx1   = '0;
    w_idx2   = '0;
    w_found1 = 1'b0;
    w_found2 = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!w_valid[i]) begin
        if (!w_found1) begin
          w_idx1   = IDX_W'(i);
          w_found1 = 1'b1;
        end else if (!w_found2) begin
          w_idx2   = IDX_W'(i);
          w_found2 = 1'b1;
        end
      end
    end
  end

  assign w_free  = f_popcnt(~w_valid);
  assign w_stall = (w_free < CNT_W'(2));
  assign w_clr   = rst | sched.flush;
  assign w_acc1  = sched.alloc_valid_1 & ~w_stall;
  assign w_acc2  = sched.alloc_valid_2 & ~w_stall;

  // Incoming rows, with same-cycle wakeup bypass.
  always_comb begin
    w_new1       = '0;
    w_new1.valid = 1'b1;
    w_new1.fu    = sched.alloc_fu_1;
    w_new1.ps1   = sched.alloc_ps1_1;
    w_new1.ps2   = sched.alloc_ps2_1;
    w_new1.rob   = sched.alloc_rob_1;
    w_new1.rdy1  = sched.alloc_rdy1_1 |
      f_hit(sched.alloc_ps1_1, sched.wb_valid, sched.wb_preg);
    w_new1.rdy2  = sched.alloc_rdy2_1 |
      f_hit(sched.alloc_ps2_1, sched.wb_valid, sched.wb_preg);
    w_new2       = '0;
    w_new2.valid = 1'b1;
    w_new2.fu    = sched.alloc_fu_2;
    w_new2.ps1   = sched.alloc_ps1_2;
    w_new2.ps2   = sched.alloc_ps2_2;
    w_new2.rob   = sched.alloc_rob_2;
    w_new2.rdy1  = sched.alloc_rdy1_2 |
      f_hit(sched.alloc_ps1_2, sched.wb_valid, sched.wb_preg);
    w_new2.rdy2  = sched.alloc_rdy2_2 |
      f_hit(sched.alloc_ps2_2, sched.wb_valid, sched.wb_preg);
  end

  // Per-FU request vectors from registered state.
  always_comb begin
    w_req = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        w_req[k][i] = r_row[i].valid &&
                      r_row[i].rdy1 && r_row[i].rdy2 &&
                      r_row[i].fu == 2'(k) &&
                      !sched.fu_busy[k];
      end
    end
  end

  for (genvar k = 0; k < NUM_FU; k++) begin : g_sel
    rs_age_select u_sel (
      .i_req   (w_req[k]),
      .i_older (r_older),
      .o_gnt   (w_gnt[k]),
      .o_idx   (w_gidx[k]),
      .o_valid (w_gval[k])
    );
  end

  // Rows leaving on any FU this cycle.
  always_comb begin
    w_issued = '0;
    for (int k = 0; k < NUM_FU; k++)
      w_issued = w_issued | w_gnt[k];
  end

  // New rows are younger than every live row;
  // slot 1 is older than slot 2.
  always_comb begin
    w_older_nxt = r_older;
    if (w_acc1) begin
      w_older_nxt[w_idx1] = '0;
      for (int j = 0; j < RS_DEPTH; j++)
        w_older_nxt[j][w_idx1] = w_valid[j];
    end
    if (w_acc2) begin
      w_older_nxt[w_idx2] = '0;
      for (int j = 0; j < RS_DEPTH; j++)
        w_older_nxt[j][w_idx2] = w_valid[j];
      if (w_acc1)
        w_older_nxt[w_idx1][w_idx2] = 1'b1;
    end
  end

  // Row state: wakeup, issue-free, allocate.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      for (int i = 0; i < RS_DEPTH; i++)
        r_row[i] <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (r_row[i].valid &&
            f_hit(r_row[i].ps1, sched.wb_valid, sched.wb_preg))
          r_row[i].rdy1 <= 1'b1;
        if (r_row[i].valid &&
            f_hit(r_row[i].ps2, sched.wb_valid, sched.wb_preg))
          r_row[i].rdy2 <= 1'b1;
        if (w_issued[i])
          r_row[i].valid <= 1'b0;
      end
      if (w_acc1)
        r_row[w_idx1] <= w_new1;
      if (w_acc2)
        r_row[w_idx2] <= w_new2;
    end
  end

  // Age matrix update.
  always_ff @(posedge clk) begin
    if (w_clr)
      r_older <= '0;
    else
      r_older <= w_older_nxt;
  end

  // Registered issue outputs per FU.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_iss_vld <= '0;
      r_iss_idx <= '0;
      r_iss_rob <= '0;
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        r_iss_vld[k] <= w_gval[k];
        r_iss_idx[k] <= w_gval[k] ? w_gidx[k] : '0;
        r_iss_rob[k] <= w_gval[k] ?
                        r_row[w_gidx[k]].rob : '0;
      end
    end
  end

  // A row aimed at a non-existent FU would never issue.
  always_ff @(posedge clk) begin
    if (!w_clr && w_acc1)
      assert (sched.alloc_fu_1 < 2'(NUM_FU))
        else $error("rs_issue_sched: slot 1 bad fu");
    if (!w_clr && w_acc2)
      assert (sched.alloc_fu_2 < 2'(NUM_FU))
        else $error("rs_issue_sched: slot 2 bad fu");
  end

  assign sched.alloc_idx_1 = w_idx1;
  assign sched.alloc_idx_2 = w_idx2;
  assign sched.alloc_stall = w_stall;
  assign sched.free_count  = w_free;
  assign sched.issue_valid = r_iss_vld;
  assign sched.issue_idx   = r_iss_idx;
  assign sched.issue_rob   = r_iss_rob;

endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed bench for rs_issue_sched.
// Expected values are hand-computed.
module tb_rs_issue_sched;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  rs_issue_sched_if bus ();

  rs_issue_sched dut (
    .clk   (clk),
    .rst   (rst),
    .sched (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush         = 1'b0;
    bus.alloc_valid_1 = 1'b0;
    bus.alloc_valid_2 = 1'b0;
    bus.alloc_fu_1    = '0;
    bus.alloc_fu_2    = '0;
    bus.alloc_ps1_1   = '0;
    bus.alloc_ps2_1   = '0;
    bus.alloc_ps1_2   = '0;
    bus.alloc_ps2_2   = '0;
    bus.alloc_rdy1_1  = 1'b0;
    bus.alloc_rdy2_1  = 1'b0;
    bus.alloc_rdy1_2  = 1'b0;
    bus.alloc_rdy2_2  = 1'b0;
    bus.alloc_rob_1   = '0;
    bus.alloc_rob_2   = '0;
    bus.wb_valid      = '0;
    bus.wb_preg       = '0;
    bus.fu_busy       = '0;
  endtask

  task automatic al1(input logic [1:0] fu,
                     input logic [5:0] p1, input logic r1,
                     input logic [5:0] p2, input logic r2,
                     input logic [3:0] rob);
    bus.alloc_valid_1 = 1'b1;
    bus.alloc_fu_1    = fu;
    bus.alloc_ps1_1   = p1;
    bus.alloc_rdy1_1  = r1;
    bus.alloc_ps2_1   = p2;
    bus.alloc_rdy2_1  = r2;
    bus.alloc_rob_1   = rob;
  endtask

  task automatic al2(input logic [1:0] fu,
                     input logic [5:0] p1, input logic r1,
                     input logic [5:0] p2, input logic r2,
                     input logic [3:0] rob);
    bus.alloc_valid_2 = 1'b1;
    bus.alloc_fu_2    = fu;
    bus.alloc_ps1_2   = p1;
    bus.alloc_rdy1_2  = r1;
    bus.alloc_ps2_2   = p2;
    bus.alloc_rdy2_2  = r2;
    bus.alloc_rob_2   = rob;
  endtask

  task automatic wb(input int k, input logic [5:0] tag);
    bus.wb_valid[k]        = 1'b1;
    bus.wb_preg[k*6 +: 6]  = tag;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // reset / idle
    chk("rst_free", bus.free_count, 16);
    chk("rst_stall", bus.alloc_stall, 0);
    chk("rst_iv", bus.issue_valid, 0);
    chk("rst_iidx", bus.issue_idx, 0);
    chk("rst_irob", bus.issue_rob, 0);
    chk("rst_idx1", bus.alloc_idx_1, 0);
    chk("rst_idx2", bus.alloc_idx_2, 1);

    // two ready fu0 rows at one edge
    al1(0, 0, 1, 0, 1, 5);
    al2(0, 0, 1, 0, 1, 6);
    tick();
    idle();
    chk("a2_free", bus.free_count, 14);
    chk("a2_iv0", bus.issue_valid, 0);
    chk("a2_idx1", bus.alloc_idx_1, 2);
    tick();
    chk("a2_iv1", bus.issue_valid, 3'b001);
    chk("a2_idx_r0", bus.issue_idx[3:0], 0);
    chk("a2_rob_r0", bus.issue_rob[3:0], 5);
    chk("a2_free1", bus.free_count, 15);
    tick();
    chk("a2_iv2", bus.issue_valid, 3'b001);
    chk("a2_idx_r1", bus.issue_idx[3:0], 1);
    chk("a2_rob_r1", bus.issue_rob[3:0], 6);
    chk("a2_free2", bus.free_count, 16);
    tick();
    chk("a2_iv3", bus.issue_valid, 0);

    // wakeup via bus 2
    al1(1, 40, 0, 7, 1, 9);
    tick();
    idle();
    tick();
    chk("wk_iv0", bus.issue_valid, 0);
    wb(2, 40);
    tick();
    idle();
    chk("wk_iv1", bus.issue_valid, 0);
    tick();
    chk("wk_iv2", bus.issue_valid, 3'b010);
    chk("wk_idx", bus.issue_idx[7:4], 0);
    chk("wk_rob", bus.issue_rob[7:4], 9);
    tick();

    // same-cycle bypass on allocate
    al1(2, 3, 1, 33, 0, 3);
    wb(0, 33);
    tick();
    idle();
    tick();
    chk("bp_iv", bus.issue_valid, 3'b100);
    chk("bp_idx", bus.issue_idx[11:8], 0);
    chk("bp_rob", bus.issue_rob[11:8], 3);
    tick();

    // slot 2 alone uses alloc_idx_2
    al2(0, 0, 1, 0, 1, 4);
    tick();
    idle();
    tick();
    chk("s2_iv", bus.issue_valid, 3'b001);
    chk("s2_idx", bus.issue_idx[3:0], 1);
    chk("s2_rob", bus.issue_rob[3:0], 4);
    tick();

    // fill all 16 rows, row r: fu=r%3, ps1=r+10
    for (int n = 0; n < 8; n++) begin
      al1(2'((2*n) % 3), 6'(2*n + 10), 0, 0, 1,
          4'(2*n));
      al2(2'((2*n+1) % 3), 6'(2*n + 11), 0, 0, 1,
          4'(2*n + 1));
      tick();
    end
    idle();
    chk("full_free", bus.free_count, 0);
    chk("full_stall", bus.alloc_stall, 1);
    al1(0, 0, 1, 0, 1, 15);
    tick();
    idle();
    chk("full_ign", bus.free_count, 0);
    chk("full_ign_iv", bus.issue_valid, 0);
    wb(0, 15);
    tick();
    idle();
    chk("full_wk_free", bus.free_count, 0);
    tick();
    chk("full_iv", bus.issue_valid, 3'b100);
    chk("full_idx", bus.issue_idx[11:8], 5);
    chk("full_rob", bus.issue_rob[11:8], 5);
    chk("full_free1", bus.free_count, 1);
    chk("full_stall1", bus.alloc_stall, 1);
    bus.flush = 1'b1;
    tick();
    idle();
    chk("fl1_free", bus.free_count, 16);
    chk("fl1_iv", bus.issue_valid, 0);

    // age beats index: row 1 older than reused row 0
    al1(0, 20, 0, 0, 1, 1);
    al2(0, 21, 0, 0, 1, 2);
    tick();
    idle();
    wb(0, 20);
    tick();
    idle();
    tick();
    chk("ag_iv0", bus.issue_rob[3:0], 1);
    chk("ag_idx1", bus.alloc_idx_1, 0);
    al1(0, 22, 0, 0, 1, 3);
    tick();
    idle();
    wb(0, 21);
    wb(1, 22);
    tick();
    idle();
    tick();
    chk("ag_first_idx", bus.issue_idx[3:0], 1);
    chk("ag_first_rob", bus.issue_rob[3:0], 2);
    tick();
    chk("ag_second_idx", bus.issue_idx[3:0], 0);
    chk("ag_second_rob", bus.issue_rob[3:0], 3);
    tick();

    // fu_busy holds back FU1 only
    al1(0, 30, 0, 0, 1, 10);
    al2(1, 30, 0, 0, 1, 11);
    tick();
    idle();
    al1(2, 30, 0, 0, 1, 12);
    tick();
    idle();
    bus.fu_busy = 3'b010;
    wb(0, 30);
    tick();
    bus.wb_valid = '0;
    tick();
    chk("bz_iv", bus.issue_valid, 3'b101);
    chk("bz_idx", bus.issue_idx, 12'h200);
    chk("bz_rob", bus.issue_rob, 12'hC0A);
    tick();
    chk("bz_iv_hold", bus.issue_valid, 0);
    bus.fu_busy = 3'b000;
    tick();
    chk("bz_iv_fu1", bus.issue_valid, 3'b010);
    chk("bz_idx_fu1", bus.issue_idx[7:4], 1);
    chk("bz_rob_fu1", bus.issue_rob[7:4], 11);
    tick();

    // flush overrides pending issue
    al1(0, 0, 1, 0, 1, 7);
    al2(0, 0, 1, 0, 1, 8);
    tick();
    idle();
    bus.flush = 1'b1;
    tick();
    idle();
    chk("fl2_iv", bus.issue_valid, 0);
    chk("fl2_free", bus.free_count, 16);
    chk("fl2_rob", bus.issue_rob, 0);
    tick();
    chk("fl2_iv_next", bus.issue_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rs_issue_sched.md
Name: rs_issue_sched

Overview:
- Issue scheduler for the 16-row reservation station, placed between dispatch and the three functional units.
- Tracks occupancy, per-source readiness and relative age of every RS row.
- Wakes sources from the three result-broadcast buses.
- Each cycle, selects the oldest ready row per FU (at most one issue per FU) and frees issued rows. Operand data stays in the RS datapath; this block moves only indices and tags.

Parameters:
- RS_DEPTH, 16, number of RS rows (power of two).
- NUM_FU, 3, functional units / result buses.
- PREG_W, 6, physical register tag width.
- ROB_W, 4, ROB index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all RS rows (same effect as rst on state)
- alloc_valid_1  in  1  dispatch slot 1 writes a row
- alloc_valid_2  in  1  dispatch slot 2 writes a row
- alloc_fu_1, alloc_fu_2  in  2 each  target FU index (0..NUM_FU-1)
- alloc_ps1_1, alloc_ps2_1, alloc_ps1_2, alloc_ps2_2  in  PREG_W each  source tags
- alloc_rdy1_1, alloc_rdy2_1, alloc_rdy1_2, alloc_rdy2_2  in  1 each  source already ready at dispatch
- alloc_rob_1, alloc_rob_2  in  ROB_W each  ROB index
- alloc_idx_1, alloc_idx_2  out  4 each  row chosen for each slot (combinational)
- alloc_stall  out  1  fewer than 2 free rows (combinational)
- wb_valid  in  NUM_FU  result bus valid
- wb_preg  in  NUM_FU*PREG_W  result bus tags, bus k at bits [k*PREG_W +: PREG_W]
- fu_busy  in  NUM_FU  FU cannot accept this cycle
- issue_valid  out  NUM_FU  registered issue strobe per FU
- issue_idx  out  NUM_FU*4  RS row issued to FU k
- issue_rob  out  NUM_FU*ROB_W  ROB index of issued row
- free_count  out  5  free rows, 0..16

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst.
- Per-row state: valid, fu[1:0], ps1, ps2, rdy1, rdy2, rob, plus a 16x16 age matrix where older[i][j]=1 means row i was allocated before row j.
- Reset/flush: all valid=0, age matrix=0, issue_valid=0, issue_idx=0, issue_rob=0. free_count reads 16 the cycle after.
- Allocation:
  - alloc_idx_1 = lowest-index free row; alloc_idx_2 = next-lowest free row.
  - Dispatch must not assert alloc_valid_* while alloc_stall=1; if it does, the request is ignored.
  - Slot 1 is older than slot 2. New rows are younger than every existing row. On write, column j of the age matrix is set from the current valid vector.
  - If only alloc_valid_2 is high, slot 2 still uses alloc_idx_2.
- Wakeup:
  - Any wb_valid[k] whose wb_preg matches a valid row's ps1/ps2 sets rdy1/rdy2 at the edge.
  - Same-cycle bypass on allocate: a matching broadcast sets the incoming rdy bit.
- Selection is combinational on registered state:
  - Candidate = valid && rdy1 && rdy2 && fu==k && !fu_busy[k].
  - Winner = the candidate no other candidate is older than.
  - Wakeups in cycle N make a row eligible in cycle N+1, not N.
- Issue:
  - At the edge, issue_valid[k] / issue_idx / issue_rob are registered from the winner.
  - The winner's valid is cleared at the same edge; the freed row is allocatable from the next cycle.
- Minimum latency: allocate with both sources ready at edge E gives issue_valid high after edge E+1.
- A row with fu==3 (>= NUM_FU) is never issued. It is a dispatch error; flag it with an assertion.
- Full: free_count=0, so alloc_stall=1. Issues in the same cycle do not relieve the stall until the next cycle.
- Simultaneous events:
  - flush/rst override alloc, wakeup and issue in the same cycle.
  - Issue-free and allocate of different rows in the same cycle are independent.

Decomposition:
- Shared package p gains constants RS_DEPTH, NUM_FU, PREG_W, ROB_W and typedef sched_row (valid, fu, ps1, ps2, rdy1, rdy2, rob).
- One natural sub-module: rs_age_select, a combinational oldest-ready picker. It takes a request vector and the age matrix and returns a one-hot grant plus index. Instantiate it NUM_FU times.

Test Plan:
- Reset then idle: free_count=16, alloc_stall=0, issue_valid=000, alloc_idx_1=0, alloc_idx_2=1.
- Alloc rows 0 (fu0, ready) and 1 (fu0, ready) at the same edge -> row 0 issues after E+1 on FU0 with its ROB index; row 1 issues one cycle later.
- Alloc row 0 with ps1=40 not ready, fu1; wb_valid[2]=1 with wb_preg=40 two cycles later -> issue_valid[1] two edges after the broadcast; issue_idx=0.
- Bypass: allocate with ps2=33 not ready while wb_preg bus 0=33 is valid in the same cycle -> issues at minimum latency.
- Fill 16 rows with unready sources -> free_count=0, alloc_stall=1. Wake one row -> it issues and free_count=1 the cycle after; alloc_stall stays 1.
- Three ready rows for fu0, fu1, fu2 with fu_busy=010 -> FU0 and FU2 issue; FU1 issues the cycle after fu_busy drops. Flush mid-stream -> issue_valid=000 and free_count=16 next cycle.
